// File: rtl/grid_walk_pkg.sv
// Shared types for the grid-walk datapath: controller FSM state encoding.
package grid_walk_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/one_bit_adder_subtractor.sv
// One-bit full adder with operand-B inversion for subtraction.
module one_bit_adder_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic sum,
  output logic cout
);

  logic b_eff;

  always_comb begin
    b_eff = b ^ sub;
    sum   = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
  end

endmodule

// File: rtl/serial_addsub_controller.sv
// Bit-serial WIDTH-bit add/subtract controller; one shared 1-bit cell, LSB first,
// start/done handshake, registered result/cout/overflow.
module serial_addsub_controller
  import grid_walk_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             adsub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CntMsb  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, adsub_q, c_msb_q, cout_q, ovf_q;
  logic             cell_sum, cell_cout;

  one_bit_adder_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sub  (adsub_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun) || (state_q == StDone);
    done = (state_q == StDone);
  end

  // Result is assembled in res_sh_q and copied out only on the last bit, so the
  // visible outputs change exactly when done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      adsub_q  <= 1'b0;
      cnt_q    <= '0;
      c_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      if (start) begin
        a_sh_q  <= a;
        b_sh_q  <= b;
        adsub_q <= adsub;
        carry_q <= adsub;
        cnt_q   <= '0;
      end
    end else if (state_q == StRun) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= {cell_sum, res_sh_q[WIDTH-1:1]};
      carry_q  <= cell_cout;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (cnt_q == CntMsb) c_msb_q <= cell_cout;
      if (cnt_q == CntLast) begin
        result_q <= {cell_sum, res_sh_q[WIDTH-1:1]};
        cout_q   <= cell_cout;
        ovf_q    <= c_msb_q ^ cell_cout;
      end
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_controller.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed cases with hand-computed expectations.
module tb_serial_addsub_controller;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             adsub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout, overflow;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_addsub_controller #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .adsub    (adsub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an op occupies WIDTH+1 cycles after acceptance; the last is done.
  int               m_left = 0;
  int               m_ops = 0;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_sub;
  logic [WIDTH-1:0] exp_res = '0;
  logic             exp_cout = 1'b0;
  logic             exp_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      exp_res  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_a    = a;
        m_b    = b;
        m_sub  = adsub;
        m_left = WIDTH + 1;
        m_ops++;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        int ua, ub, us, sa, sb, sr;
        ua = int'(m_a);
        ub = int'(m_b);
        sa = int'($signed(m_a));
        sb = int'($signed(m_b));
        us = m_sub ? ua + ((1 << WIDTH) - 1 - ub) + 1 : ua + ub;
        sr = m_sub ? sa - sb : sa + sb;
        exp_res  = WIDTH'(us);
        exp_cout = ((us >> WIDTH) & 1) != 0;
        exp_ovf  = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
      end
    end
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("result", 32'(result), 32'(exp_res));
    chk("cout", 32'(cout), 32'(exp_cout));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (done) chk("done_single_pulse", 32'(prev_done), 32'd0);
    prev_done = done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic sub, input logic [WIDTH-1:0] er, input logic ec,
                        input logic eo, input string name);
    int k;
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = op_a; b = op_b; adsub = sub;
    @(posedge clk); #2;
    start = 1'b0; a = $urandom; b = $urandom; adsub = $urandom_range(0, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    chk({name, "_latency"}, 32'(k), 32'd9);
    chk({name, "_result"}, 32'(result), 32'(er));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "add_100_27");
    run_op(8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1, "add_127_1");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_1");
    run_op(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_5_7");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_1");

    // start held high with operands changing every cycle
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      a = $urandom; b = $urandom; adsub = $urandom_range(0, 1);
      @(negedge clk);
      if (done) n++;
    end
    chk("held_start_done_count", 32'(n), 32'd5);
    start = 1'b0;

    // reset in the 4th RUN cycle
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'd55; b = 8'd66; adsub = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_result", 32'(result), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "after_reset");

    // random traffic, start frequently asserted including while busy
    n = m_ops;
    for (int i = 0; i < 13000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; adsub = $urandom_range(0, 1);
    end
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    chk("random_op_count", 32'(m_ops - n >= 1000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
